esc_pwm_out: RTL and testbench

Output stage downstream of the PPM decoder: consumes the decoder's 13 median-filtered channel values (0..999), applies an arm/disarm safety state machine, and generates N_OUT servo/ESC PWM pulses of 1000 + value µs once per output frame. Runs on the same 1 MHz system clock as the decoder, so one cycle is one microsecond. Drives the motor ESC pins directly.

---
 rtl/esc_pkg.sv | 27 ++
 rtl/pwm_channel.sv | 24 ++
 rtl/esc_pwm_out.sv | 130 +++++++++++++
 tb/tb_esc_pwm_out.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/esc_pkg.sv
// esc_pkg: shared types and constants for the ESC/servo PWM output stage.
//   arm_state_t : arm/disarm safety FSM states
//   CH_COUNT    : number of decoder channels presented to the output stage
//   CH_W        : bit width of one channel value
//   CH_MAX      : largest meaningful channel value; larger inputs are clamped
//   WID_W       : width of the frame counter and pulse-width arithmetic
package esc_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2
  } arm_state_t;

  localparam int CH_COUNT = 13;
  localparam int CH_W     = 12;
  localparam int CH_MAX   = 999;
  localparam int WID_W    = 15;

  // Clamp a raw channel value into 0..CH_MAX and widen it for width arithmetic.
  function automatic logic [WID_W-1:0] clamp_ch(input logic [CH_W-1:0] v);
    logic [CH_W-1:0] c;
    c = (v > CH_W'(CH_MAX)) ? CH_W'(CH_MAX) : v;
    return WID_W'(c);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output bit driven from the shared frame counter.
//   clk   : system clock (1 MHz, one cycle per microsecond)
//   rst   : asynchronous active-high reset, forces the pin low at once
//   cnt   : frame counter, 0..PERIOD_US-1
//   width : pulse width in cycles for the current frame
//   pwm   : registered pulse output
// The compare is registered, so the pin rises on the edge after cnt = 0 and
// stays high for exactly width cycles.
module pwm_channel
  import esc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WID_W-1:0] cnt,
  input  logic [WID_W-1:0] width,
  output logic             pwm
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm <= 1'b0;
    else     pwm <= (cnt < width);
  end

endmodule

// File: rtl/esc_pwm_out.sv
// esc_pwm_out: ESC/servo output stage behind the PPM decoder.
//   clk   : system clock, 1 MHz
//   rst   : asynchronous active-high reset
//   ch    : CH_COUNT decoder channel values, nominally 0..999
//   pwm   : N_OUT pulse outputs, 1000 + value us while armed, MIN_US otherwise
//   armed : high while the safety FSM is in ARMED
//   frame : one-cycle strobe during the cycle in which cnt = 0
// Everything that changes the pulse shape (channel sampling, FSM step, width
// latch) happens on the single wrap edge of the frame counter, so a pulse is
// never truncated or stretched mid-frame.
module esc_pwm_out
  import esc_pkg::*;
#(
  parameter int N_OUT       = 4,
  parameter int PERIOD_US   = 20000,
  parameter int MIN_US      = 1000,
  parameter int THR_CH      = 2,
  parameter int ARM_CH      = 4,
  parameter int THR_ARM_MAX = 50,
  parameter int ARM_SW_MIN  = 500,
  parameter int ARM_FRAMES  = 25
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CH_COUNT-1:0][CH_W-1:0]    ch,
  output logic [N_OUT-1:0]                 pwm,
  output logic                             armed,
  output logic                             frame
);

  localparam int AC_W = $clog2(ARM_FRAMES + 1);

  logic [WID_W-1:0]              cnt;
  logic                          wrap;
  arm_state_t                    state;
  logic [AC_W-1:0]               arm_cnt;
  logic [AC_W-1:0]               arm_cnt_inc;
  logic [N_OUT-1:0][WID_W-1:0]   width;
  logic [N_OUT-1:0][WID_W-1:0]   w_armed;
  logic [N_OUT-1:0][WID_W-1:0]   w_min;
  logic                          sw_on;
  logic                          q;
  logic                          unused_ch;

  // Only a few channels feed this stage; the rest are deliberately ignored.
  assign unused_ch = ^ch;

  assign wrap        = (cnt == WID_W'(PERIOD_US - 1));
  assign sw_on       = (ch[ARM_CH] >= CH_W'(ARM_SW_MIN));
  assign q           = (ch[THR_CH] < CH_W'(THR_ARM_MAX)) && sw_on;
  assign arm_cnt_inc = arm_cnt + AC_W'(1);

  // Frame counter and boundary strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      frame <= 1'b0;
    end else begin
      frame <= wrap;
      cnt   <= wrap ? '0 : cnt + WID_W'(1);
    end
  end

  // Candidate widths for the next frame, one per output.
  for (genvar i = 0; i < N_OUT; i++) begin : g_w
    assign w_armed[i] = WID_W'(MIN_US) + clamp_ch(ch[i]);
    assign w_min[i]   = WID_W'(MIN_US);
  end

  // Arm FSM. Steps only on the frame edge; widths and armed are latched from
  // the state being entered, so a disarm already yields MIN_US pulses in the
  // very next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DISARMED;
      arm_cnt <= '0;
      armed   <= 1'b0;
      width   <= w_min;
    end else if (wrap) begin
      width <= w_min;
      armed <= 1'b0;
      case (state)
        DISARMED: begin
          if (q) begin
            state   <= ARMING;
            arm_cnt <= AC_W'(1);
          end
        end
        ARMING: begin
          if (!q) begin
            state   <= DISARMED;
            arm_cnt <= '0;
          end else begin
            arm_cnt <= arm_cnt_inc;
            if (arm_cnt_inc == AC_W'(ARM_FRAMES)) begin
              state <= ARMED;
              armed <= 1'b1;
              width <= w_armed;
            end
          end
        end
        ARMED: begin
          // Throttle is ignored once armed; only the switch can disarm.
          if (!sw_on) begin
            state   <= DISARMED;
            arm_cnt <= '0;
          end else begin
            armed <= 1'b1;
            width <= w_armed;
          end
        end
        default: begin
          state   <= DISARMED;
          arm_cnt <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_ch
    pwm_channel u_ch (
      .clk   (clk),
      .rst   (rst),
      .cnt   (cnt),
      .width (width[i]),
      .pwm   (pwm[i])
    );
  end

endmodule

// File: tb/tb_esc_pwm_out.sv
// Bench for esc_pwm_out. Frame length and arm count are shortened so the whole
// sequence fits in a modest number of cycles; MIN_US and the channel range are
// kept, so the pulse widths match the nominal values (1000, 1500, 1999 ...).
module tb_esc_pwm_out;
  import esc_pkg::*;

  localparam int N     = 4;
  localparam int P     = 2050;
  localparam int MINW  = 1000;
  localparam int TC    = 2;
  localparam int AC    = 4;
  localparam int TMAX  = 50;
  localparam int SWMIN = 500;
  localparam int AF    = 4;
  localparam int CK    = P - 20;   // point in a frame where its pulse is over

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH_COUNT-1:0][CH_W-1:0] ch;
  logic [N-1:0] pwm;
  logic armed, frame;

  always #5 clk = ~clk;

  esc_pwm_out #(
    .N_OUT(N), .PERIOD_US(P), .MIN_US(MINW), .THR_CH(TC), .ARM_CH(AC),
    .THR_ARM_MAX(TMAX), .ARM_SW_MIN(SWMIN), .ARM_FRAMES(AF)
  ) dut (
    .clk(clk), .rst(rst), .ch(ch), .pwm(pwm), .armed(armed), .frame(frame)
  );

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;          // cycles since reset release; cnt = cyc % P
  bit m_armed;
  int streak;            // consecutive qualifying frame edges while not armed
  int wm[N];
  int hi[N];
  int last_w[N];

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > CH_MAX) ? CH_MAX : v;
  endfunction

  // Reference model: pulse i is high in cnt = 1..wm[i]; frame at cnt = 0 of
  // every frame after the first; all decisions taken from ch at the wrap.
  initial begin : model
    int c;
    logic [N-1:0] e;
    bit sw, q;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; m_armed = 0; streak = 0;
        for (int i = 0; i < N; i++) wm[i] = MINW;
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_frame", int'(frame), 0);
      end else begin
        c = cyc % P;
        for (int i = 0; i < N; i++) e[i] = (c >= 1) && (c <= wm[i]);
        chk("pwm", int'(pwm), int'(e));
        chk("frame", int'(frame), int'(c == 0 && cyc != 0));
        chk("armed", int'(armed), int'(m_armed));
        if (c == P - 1) begin
          sw = int'(ch[AC]) >= SWMIN;
          q  = (int'(ch[TC]) < TMAX) && sw;
          if (m_armed) begin
            if (!sw) begin m_armed = 0; streak = 0; end
          end else begin
            streak = q ? streak + 1 : 0;
            if (streak == AF) m_armed = 1;
          end
          for (int i = 0; i < N; i++)
            wm[i] = m_armed ? MINW + clampv(int'(ch[i])) : MINW;
        end
        cyc++;
      end
    end
  end

  // Measured width of the most recent completed pulse on each output.
  initial begin : meas
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst) hi[i] = 0;
        else if (pwm[i]) hi[i]++;
        else if (hi[i] > 0) begin last_w[i] = hi[i]; hi[i] = 0; end
      end
    end
  end

  // Advance to the cycle with cnt = c (always at least one edge ahead).
  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while ((cyc % P) != c && n <= P + 2);
    if ((cyc % P) != c) chk("wait_timeout", cyc % P, c);
  endtask

  initial begin : stim
    int c;
    ch = '0;
    for (int i = 0; i < N; i++) last_w[i] = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // idle: disarmed, MIN_US pulses
    wait_cnt(CK);
    chk("idle_w0", last_w[0], 1000);
    wait_cnt(0); wait_cnt(CK);
    chk("idle_w3", last_w[3], 1000);
    chk("idle_armed", int'(armed), 0);

    // arm sequence
    wait_cnt(5);
    ch[2] = 12'd10; ch[4] = 12'd900; ch[0] = 12'd500;
    repeat (3) wait_cnt(5);
    chk("arm_edge3", int'(armed), 0);
    chk("arm_w_before", last_w[0], 1000);
    wait_cnt(5);
    chk("arm_edge4", int'(armed), 1);
    wait_cnt(CK);
    chk("arm_w1500", last_w[0], 1500);

    // randomized traffic, changes anywhere in the frame incl. just before wrap
    repeat (4) begin
      case ($urandom % 3)
        0: c = 1;
        1: c = P - 1;
        default: c = int'($urandom_range(1, P - 2));
      endcase
      wait_cnt(c);
      for (int k = 0; k < CH_COUNT; k++) ch[k] = 12'($urandom_range(0, 4095));
      ch[2] = 12'($urandom_range(0, 80));
      ch[4] = ($urandom % 4 != 0) ? 12'($urandom_range(500, 4095))
                                  : 12'($urandom_range(0, 499));
    end

    // aborted arm
    wait_cnt(5);
    ch = '0;
    wait_cnt(5);
    chk("pre_abort_disarmed", int'(armed), 0);
    ch[2] = 12'd10; ch[4] = 12'd900; ch[0] = 12'd500;
    repeat (2) wait_cnt(5);
    ch[2] = 12'd200;
    wait_cnt(5);
    chk("abort_armed", int'(armed), 0);
    ch[2] = 12'd10;
    repeat (3) wait_cnt(5);
    chk("rearm_edge3", int'(armed), 0);
    wait_cnt(5);
    chk("rearm_edge4", int'(armed), 1);

    // clamp and range on output 1
    ch[1] = 12'd0;
    wait_cnt(0); wait_cnt(CK);
    chk("clamp_0", last_w[1], 1000);
    ch[1] = 12'd999;
    wait_cnt(0); wait_cnt(CK);
    chk("clamp_999", last_w[1], 1999);
    ch[1] = 12'd4095;
    wait_cnt(0); wait_cnt(CK);
    chk("clamp_4095", last_w[1], 1999);

    // change one cycle after the frame edge waits for the next frame
    wait_cnt(1);
    ch[0] = 12'd200;
    wait_cnt(CK);
    chk("late_change_same", last_w[0], 1500);
    wait_cnt(CK);
    chk("late_change_next", last_w[0], 1200);

    // disarm mid-frame
    wait_cnt(500);
    ch[4] = 12'd100;
    chk("disarm_midpulse", int'(pwm[0]), 1);
    wait_cnt(CK);
    chk("disarm_cur_w", last_w[0], 1200);
    chk("disarm_cur_armed", int'(armed), 1);
    wait_cnt(CK);
    chk("disarm_next_w", last_w[0], 1000);
    chk("disarm_next_armed", int'(armed), 0);

    // async reset mid-pulse while armed at width 1800
    ch[4] = 12'd900; ch[0] = 12'd800; ch[2] = 12'd10;
    repeat (4) wait_cnt(0);
    chk("rst_pre_armed", int'(armed), 1);
    wait_cnt(700);
    chk("rst_pre_pwm", int'(pwm[0]), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_pwm", int'(pwm), 0);
    chk("async_armed", int'(armed), 0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    wait_cnt(CK);
    chk("post_rst_w", last_w[0], 1000);
    chk("post_rst_armed", int'(armed), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
